// File: rtl/ecc_modarith_pkg.sv
// ----------------------------------------------------------------------------
// ecc_modarith_pkg
// Shared types for the ECC modular-arithmetic engine.
//   op_e    : request opcode (SETMOD / ADD / SUB / MUL)
//   state_e : engine FSM state, also exported on the debug state output
// The result record {id, data, err} depends on WIDTH/ID_WIDTH. It is
// therefore declared as a packed struct inside the module that uses it.
// ----------------------------------------------------------------------------
package ecc_modarith_pkg;

  localparam int OP_W = 2;

  typedef enum logic [OP_W-1:0] {
    OP_SETMOD = 2'd0,
    OP_ADD    = 2'd1,
    OP_SUB    = 2'd2,
    OP_MUL    = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PUSH = 2'd2
  } state_e;

endpackage

// File: rtl/ecc_modarith_if.sv
// ----------------------------------------------------------------------------
// ecc_modarith_if
// Request/result bundle between the issue FSM (master) and the modular
// arithmetic engine (slave).
//
// Handshake semantics (both channels):
//   A transfer happens on a rising clock edge where valid and ready are both
//   high. The source holds valid and its payload stable until that transfer.
//   ready may depend combinationally on the sink's state, and on kill_i for
//   the request channel. It never depends on valid.
//   Request channel : req_valid_i / req_ready_o, payload req_op_i, req_id_i,
//                     req_a_i, req_b_i.
//   Result channel  : res_valid_o / res_ready_i, payload res_id_o,
//                     res_data_o, res_err_o. The payload is all-zero while
//                     res_valid_o is low.
// Side-band: kill_i (abort an in-flight MUL), busy_o, modulus_o.
// ----------------------------------------------------------------------------
interface ecc_modarith_if #(
  parameter int WIDTH    = 64,
  parameter int ID_WIDTH = 3
);
  logic                req_valid_i;
  logic                req_ready_o;
  logic [1:0]          req_op_i;
  logic [ID_WIDTH-1:0] req_id_i;
  logic [WIDTH-1:0]    req_a_i;
  logic [WIDTH-1:0]    req_b_i;
  logic                kill_i;
  logic                res_valid_o;
  logic                res_ready_i;
  logic [ID_WIDTH-1:0] res_id_o;
  logic [WIDTH-1:0]    res_data_o;
  logic                res_err_o;
  logic                busy_o;
  logic [WIDTH-1:0]    modulus_o;

  modport master (
    output req_valid_i, req_op_i, req_id_i, req_a_i, req_b_i, kill_i, res_ready_i,
    input  req_ready_o, res_valid_o, res_id_o, res_data_o, res_err_o, busy_o, modulus_o
  );

  modport slave (
    input  req_valid_i, req_op_i, req_id_i, req_a_i, req_b_i, kill_i, res_ready_i,
    output req_ready_o, res_valid_o, res_id_o, res_data_o, res_err_o, busy_o, modulus_o
  );
endinterface

// File: rtl/ecc_modarith_resq.sv
// ----------------------------------------------------------------------------
// ecc_modarith_resq
// First-word-fall-through result FIFO with DEPTH entries. DEPTH does not
// have to be a power of two: the pointers wrap explicitly.
// Ports:
//   clk_i, rst_i : clock, synchronous active-high reset
//   i_push       : write i_push_data. Ignored when full.
//   i_pop        : pop the head. Ignored when empty.
//   o_full       : count == DEPTH
//   o_valid      : head entry present
//   o_data       : head entry. All-zero when empty.
// Push and pop in the same cycle are both honoured.
// ----------------------------------------------------------------------------
module ecc_modarith_resq #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_push_data,
  input  logic              i_pop,
  output logic              o_full,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              w_do_push;
  logic              w_do_pop;

  function automatic logic [PTR_W-1:0] f_next(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_valid   = (r_count != '0);
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & o_valid;
  assign o_data    = o_valid ? r_mem[r_rd_ptr] : '0;

  // Storage needs no reset: the read port is gated by o_valid.
  always_ff @(posedge clk_i) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= f_next(r_wr_ptr);
      if (w_do_pop)  r_rd_ptr <= f_next(r_rd_ptr);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/ecc_modarith_engine.sv
// ----------------------------------------------------------------------------
// ecc_modarith_engine
// Modular-arithmetic engine for the ECC coprocessor. It owns a modulus
// register and runs SETMOD/ADD/SUB/MUL on WIDTH-bit operands. Each op
// carries an id. Results leave in issue order through a RESQ_DEPTH-entry
// result queue.
// Ports:
//   clk_i, rst_i : clock, synchronous active-high reset
//   bus          : ecc_modarith_if slave modport. It carries:
//                  - request channel: req_*
//                  - result channel: res_*
//                  - kill_i, busy_o, modulus_o
//   dbg_state_o  : current FSM state (state_e encoding)
// Timing:
//   SETMOD, ADD and SUB complete on their handshake edge.
//   MUL runs WIDTH shift-and-add iterations, MSB of b first:
//   - The first iteration is folded into the issue edge.
//   - The remaining WIDTH-1 iterations run in RUN.
//   - PUSH then writes the entry.
//   busy_o is therefore high for exactly WIDTH cycles.
// ----------------------------------------------------------------------------
module ecc_modarith_engine
  import ecc_modarith_pkg::*;
#(
  parameter int WIDTH      = 64,
  parameter int ID_WIDTH   = 3,
  parameter int RESQ_DEPTH = 2
) (
  input  logic          clk_i,
  input  logic          rst_i,
  ecc_modarith_if.slave bus,
  output logic [1:0]    dbg_state_o
);
  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam int IDX_W = $clog2(WIDTH);
  localparam int RES_W = ID_WIDTH + WIDTH + 1;

  typedef struct packed {
    logic [ID_WIDTH-1:0] id;
    logic [WIDTH-1:0]    data;
    logic                err;
  } res_t;

  state_e              r_state;
  logic [WIDTH-1:0]    r_mod;
  logic [WIDTH-1:0]    r_a;
  logic [WIDTH-1:0]    r_b;
  logic [WIDTH-1:0]    r_p;
  logic [WIDTH-1:0]    r_acc;
  logic [CNT_W-1:0]    r_cnt;
  logic [ID_WIDTH-1:0] r_id;
  logic                r_err;
  logic                r_busy;

  op_e                 w_op;
  logic                w_accept;
  logic                w_full;
  logic                w_push;
  logic                w_head_valid;
  logic                w_mod_zero;
  logic                w_next_bit;
  res_t                w_push_ent;
  res_t                w_head;
  logic [RES_W-1:0]    w_head_bits;
  logic [WIDTH-1:0]    w_add_res;
  logic [WIDTH-1:0]    w_sub_res;
  logic [WIDTH-1:0]    w_mul_first;
  logic [WIDTH-1:0]    w_mul_next;

  // ADD: the sum is kept at WIDTH+1 bits so the carry takes part in the
  // compare with p.
  function automatic logic [WIDTH-1:0] f_add(input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b,
                                             input logic [WIDTH-1:0] p);
    logic [WIDTH:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, p}) s = s - {1'b0, p};
    return s[WIDTH-1:0];
  endfunction

  // SUB: wraps mod 2^WIDTH when adding p back.
  function automatic logic [WIDTH-1:0] f_sub(input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b,
                                             input logic [WIDTH-1:0] p);
    return (a >= b) ? (a - b) : (a - b + p);
  endfunction

  // One interleaved multiply step:
  //   1. acc = 2*acc mod p
  //   2. if the b bit is set, acc = acc + a mod p
  function automatic logic [WIDTH-1:0] f_mul_step(input logic [WIDTH-1:0] acc,
                                                  input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] p,
                                                  input logic             b_bit);
    logic [WIDTH:0] t;
    logic [WIDTH:0] pp;
    pp = {1'b0, p};
    t  = {acc, 1'b0};
    if (t >= pp) t = t - pp;
    if (b_bit) begin
      t = t + {1'b0, a};
      if (t >= pp) t = t - pp;
    end
    return t[WIDTH-1:0];
  endfunction

  assign w_op        = op_e'(bus.req_op_i);
  assign w_mod_zero  = (r_mod == '0);
  assign w_add_res   = f_add(bus.req_a_i, bus.req_b_i, r_mod);
  assign w_sub_res   = f_sub(bus.req_a_i, bus.req_b_i, r_mod);
  assign w_mul_first = f_mul_step('0, bus.req_a_i, r_mod, bus.req_b_i[WIDTH-1]);
  assign w_next_bit  = r_b[r_cnt[IDX_W-1:0]];
  assign w_mul_next  = f_mul_step(r_acc, r_a, r_p, w_next_bit);

  // kill_i also blocks acceptance. An op therefore never starts in the
  // cycle that aborts another one.
  assign bus.req_ready_o = (r_state == ST_IDLE) & ~w_full & ~bus.kill_i;
  assign w_accept        = bus.req_valid_i & bus.req_ready_o;

  // There are two push sources:
  //   - single-cycle ops at issue
  //   - the MUL in PUSH, unless killed
  // Only one of them can be active at a time.
  always_comb begin
    w_push     = 1'b0;
    w_push_ent = '0;
    if (w_accept && (w_op != OP_MUL)) begin
      w_push        = 1'b1;
      w_push_ent.id = bus.req_id_i;
      case (w_op)
        OP_SETMOD: w_push_ent.err = (bus.req_a_i == '0);
        OP_ADD: begin
          if (w_mod_zero) w_push_ent.err  = 1'b1;
          else            w_push_ent.data = w_add_res;
        end
        OP_SUB: begin
          if (w_mod_zero) w_push_ent.err  = 1'b1;
          else            w_push_ent.data = w_sub_res;
        end
        default: w_push_ent.err = 1'b0;
      endcase
    end else if ((r_state == ST_PUSH) && !bus.kill_i) begin
      w_push          = 1'b1;
      w_push_ent.id   = r_id;
      w_push_ent.err  = r_err;
      w_push_ent.data = r_err ? '0 : r_acc;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_mod   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_p     <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_id    <= '0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            if (w_op == OP_SETMOD) r_mod <= bus.req_a_i;
            if (w_op == OP_MUL) begin
              // Operands and modulus are captured here. A later SETMOD
              // cannot disturb a running multiply.
              r_a     <= bus.req_a_i;
              r_b     <= bus.req_b_i;
              r_p     <= r_mod;
              r_id    <= bus.req_id_i;
              r_err   <= w_mod_zero;
              r_acc   <= w_mul_first;
              r_cnt   <= CNT_W'(WIDTH - 2);
              r_busy  <= 1'b1;
              r_state <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (bus.kill_i) begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_acc <= w_mul_next;
            if (r_cnt == '0) r_state <= ST_PUSH;
            else             r_cnt   <= r_cnt - 1'b1;
          end
        end
        ST_PUSH: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  ecc_modarith_resq #(
    .DATA_W(RES_W),
    .DEPTH (RESQ_DEPTH)
  ) u_resq (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .i_push     (w_push),
    .i_push_data(w_push_ent),
    .i_pop      (bus.res_ready_i),
    .o_full     (w_full),
    .o_valid    (w_head_valid),
    .o_data     (w_head_bits)
  );

  assign w_head          = res_t'(w_head_bits);
  assign bus.res_valid_o = w_head_valid;
  assign bus.res_id_o    = w_head.id;
  assign bus.res_data_o  = w_head.data;
  assign bus.res_err_o   = w_head.err;
  assign bus.busy_o      = r_busy;
  assign bus.modulus_o   = r_mod;
  assign dbg_state_o     = r_state;
endmodule

// File: tb/tb_ecc_modarith_engine.sv
module tb_ecc_modarith_engine;
  import ecc_modarith_pkg::*;

  localparam int W     = 64;
  localparam int IDW   = 3;
  localparam int EXP_W = IDW + W + 1;

  logic             clk;
  logic             rst;
  logic [1:0]       dbg64;
  logic [1:0]       dbg8;
  int               n_checks;
  int               n_errors;
  logic [W-1:0]     model_mod;
  logic [EXP_W-1:0] exp_q[$];

  ecc_modarith_if #(.WIDTH(W), .ID_WIDTH(IDW)) bus ();
  ecc_modarith_if #(.WIDTH(8), .ID_WIDTH(IDW)) b8 ();

  ecc_modarith_engine #(.WIDTH(W), .ID_WIDTH(IDW), .RESQ_DEPTH(2)) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus.slave), .dbg_state_o(dbg64)
  );

  ecc_modarith_engine #(.WIDTH(8), .ID_WIDTH(IDW), .RESQ_DEPTH(2)) dut8 (
    .clk_i(clk), .rst_i(rst), .bus(b8.slave), .dbg_state_o(dbg8)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference result of one op, computed from the arithmetic definition.
  // MUL uses a full 128-bit product reduced mod p.
  function automatic logic [EXP_W-1:0] model_res(input logic [1:0] op, input logic [IDW-1:0] id,
                                                 input logic [W-1:0] a, input logic [W-1:0] b,
                                                 input logic [W-1:0] p);
    logic [W:0]     s;
    logic [127:0]   prod;
    logic [W-1:0]   d;
    logic           e;
    d = '0;
    e = 1'b0;
    if (op == 2'd0) e = (a == '0);
    else if (p == '0) e = 1'b1;
    else begin
      case (op)
        2'd1: begin
          s = {1'b0, a} + {1'b0, b};
          if (s >= {1'b0, p}) s = s - {1'b0, p};
          d = s[W-1:0];
        end
        2'd2: d = (a >= b) ? (a - b) : (a - b + p);
        default: begin
          prod = {64'd0, a} * {64'd0, b};
          prod = prod % {64'd0, p};
          d = prod[W-1:0];
        end
      endcase
    end
    return {id, d, e};
  endfunction

  // ---------------- scoreboard compare (every cycle) ----------------
  always @(negedge clk) begin : compare
    logic [EXP_W-1:0] got;
    got = {bus.res_id_o, bus.res_data_o, bus.res_err_o};
    if (bus.res_valid_o) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_result: got %0h with no result outstanding", got);
      end else begin
        chk("result_head", got, exp_q[0]);
        if (bus.res_ready_i) void'(exp_q.pop_front());
      end
    end else begin
      chk("empty_res_zero", got, '0);
    end
    chk("modulus", bus.modulus_o, model_mod);
  end

  // ---------------- driver tasks (call at posedge + 1) ----------------
  task automatic issue(input logic [1:0] op, input logic [IDW-1:0] id,
                       input logic [W-1:0] a, input logic [W-1:0] b, output int waited);
    bus.req_op_i    = op;
    bus.req_id_i    = id;
    bus.req_a_i     = a;
    bus.req_b_i     = b;
    bus.req_valid_i = 1'b1;
    waited = 0;
    @(negedge clk);
    while (!bus.req_ready_o && waited < 50) begin
      waited++;
      @(negedge clk);
    end
    n_checks++;
    if (!bus.req_ready_o) begin
      n_errors++;
      $display("FAIL issue_timeout: id %0d ready 0 after %0d cycles, required 1", id, waited);
      bus.req_valid_i = 1'b0;
    end else begin
      @(posedge clk);
      exp_q.push_back(model_res(op, id, a, b, model_mod));
      if (op == 2'd0) model_mod = a;
      #1 bus.req_valid_i = 1'b0;
    end
  endtask

  task automatic issue8(input logic [1:0] op, input logic [IDW-1:0] id,
                        input logic [7:0] a, input logic [7:0] b);
    int waited;
    b8.req_op_i    = op;
    b8.req_id_i    = id;
    b8.req_a_i     = a;
    b8.req_b_i     = b;
    b8.req_valid_i = 1'b1;
    waited = 0;
    @(negedge clk);
    while (!b8.req_ready_o && waited < 50) begin
      waited++;
      @(negedge clk);
    end
    chk("w8_issue_ready", b8.req_ready_o, 1);
    @(posedge clk);
    #1 b8.req_valid_i = 1'b0;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    n_checks++;
    n_errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // ---------------- directed stimulus ----------------
  initial begin : main
    int w;
    int first_k;
    int busy_cnt;
    int ready_cnt;
    logic [W-1:0] data_at;
    logic [7:0] data8;

    n_checks  = 0;
    n_errors  = 0;
    model_mod = '0;
    rst = 1'b1;
    bus.req_valid_i = 0; bus.req_op_i = 0; bus.req_id_i = 0; bus.req_a_i = 0; bus.req_b_i = 0;
    bus.kill_i = 0; bus.res_ready_i = 1'b1;
    b8.req_valid_i = 0; b8.req_op_i = 0; b8.req_id_i = 0; b8.req_a_i = 0; b8.req_b_i = 0;
    b8.kill_i = 0; b8.res_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_res_valid", bus.res_valid_o, 0);
    chk("rst_busy", bus.busy_o, 0);
    chk("rst_modulus", bus.modulus_o, 0);
    chk("rst_req_ready", bus.req_ready_o, 1);
    chk("rst_state", dbg64, 0);
    step();

    // 1. SETMOD 97, ADD 90+20 -> 13, SUB 5-9 -> 93, each valid at N+1
    issue(2'd0, 3'd1, 64'd97, 64'd0, w);
    @(negedge clk);
    chk("setmod_lat", bus.res_valid_o, 1);
    chk("setmod_res", {bus.res_data_o, bus.res_err_o}, {64'd0, 1'b0});
    step();
    issue(2'd1, 3'd2, 64'd90, 64'd20, w);
    @(negedge clk);
    chk("add_lat", bus.res_valid_o, 1);
    chk("add_res", {bus.res_id_o, bus.res_data_o, bus.res_err_o}, {3'd2, 64'd13, 1'b0});
    step();
    issue(2'd2, 3'd3, 64'd5, 64'd9, w);
    @(negedge clk);
    chk("sub_lat", bus.res_valid_o, 1);
    chk("sub_res", bus.res_data_o, 93);
    step();

    // 2. MUL 96*96 mod 97 -> 1 at N+65, busy 64 cycles
    issue(2'd3, 3'd4, 64'd96, 64'd96, w);
    busy_cnt = 0;
    first_k  = 0;
    data_at  = '0;
    for (int k = 1; k <= W + 1; k++) begin
      @(negedge clk);
      if (bus.busy_o) busy_cnt++;
      if (bus.res_valid_o && first_k == 0) begin
        first_k = k;
        data_at = bus.res_data_o;
      end
    end
    chk("mul_busy_cycles", busy_cnt, 64);
    chk("mul_latency", first_k, 65);
    chk("mul_data", data_at, 1);
    step();

    // 3. Back-pressure: third ADD stalls until a pop
    bus.res_ready_i = 1'b0;
    issue(2'd1, 3'd1, 64'd1, 64'd2, w);
    issue(2'd1, 3'd2, 64'd3, 64'd4, w);
    bus.req_op_i = 2'd1; bus.req_id_i = 3'd3; bus.req_a_i = 64'd5; bus.req_b_i = 64'd6;
    bus.req_valid_i = 1'b1;
    ready_cnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.req_ready_o) ready_cnt++;
    end
    chk("full_stall_ready", ready_cnt, 0);
    chk("full_head_id", bus.res_id_o, 1);
    step();
    bus.res_ready_i = 1'b1;
    issue(2'd1, 3'd3, 64'd5, 64'd6, w);
    chk("stall_release_wait", w, 1);
    repeat (4) @(negedge clk);
    chk("bp_drained", exp_q.size(), 0);
    step();

    // 4. kill 10 cycles into MUL id 5
    issue(2'd3, 3'd5, 64'd50, 64'd60, w);
    repeat (9) @(posedge clk);
    #1 bus.kill_i = 1'b1;
    @(negedge clk);
    chk("kill_busy_before", bus.busy_o, 1);
    chk("kill_blocks_ready", bus.req_ready_o, 0);
    @(posedge clk);
    void'(exp_q.pop_back());
    #1 bus.kill_i = 1'b0;
    issue(2'd1, 3'd6, 64'd10, 64'd20, w);
    chk("kill_next_issue_wait", w, 0);
    @(negedge clk);
    chk("kill_busy_after", bus.busy_o, 0);
    chk("kill_add_res", {bus.res_id_o, bus.res_data_o}, {3'd6, 64'd30});
    step();

    // 5. p == 0 errors after reset
    rst = 1'b1;
    @(posedge clk);
    exp_q.delete();
    model_mod = '0;
    #1 rst = 1'b0;
    issue(2'd1, 3'd1, 64'd3, 64'd4, w);
    @(negedge clk);
    chk("p0_add", {bus.res_valid_o, bus.res_data_o, bus.res_err_o}, {1'b1, 64'd0, 1'b1});
    step();
    issue(2'd0, 3'd2, 64'd0, 64'd0, w);
    @(negedge clk);
    chk("setmod0_err", bus.res_err_o, 1);
    step();
    issue(2'd0, 3'd3, 64'd7, 64'd0, w);
    issue(2'd1, 3'd4, 64'd3, 64'd4, w);
    @(negedge clk);
    chk("p7_add", {bus.res_id_o, bus.res_data_o, bus.res_err_o}, {3'd4, 64'd0, 1'b0});
    step();

    // 6. reset mid-MUL with one queued entry
    issue(2'd0, 3'd1, 64'd97, 64'd0, w);
    step();
    bus.res_ready_i = 1'b0;
    issue(2'd1, 3'd2, 64'd1, 64'd1, w);
    issue(2'd3, 3'd3, 64'd3, 64'd4, w);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("pre_rst_queued", bus.res_valid_o, 1);
    chk("pre_rst_busy", bus.busy_o, 1);
    @(posedge clk);
    exp_q.delete();
    model_mod = '0;
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_valid", bus.res_valid_o, 0);
    chk("post_rst_modulus", bus.modulus_o, 0);
    chk("post_rst_busy", bus.busy_o, 0);
    chk("post_rst_state", dbg64, 0);
    bus.res_ready_i = 1'b1;
    repeat (80) @(negedge clk);
    step();

    // WIDTH=8 build: MUL 200*200 mod 251 -> 91 at N+9
    issue8(2'd0, 3'd6, 8'd251, 8'd0);
    @(negedge clk);
    chk("w8_modulus", b8.modulus_o, 251);
    step();
    issue8(2'd3, 3'd7, 8'd200, 8'd200);
    first_k = 0;
    data8   = '0;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (b8.res_valid_o && first_k == 0) begin
        first_k = k;
        data8   = b8.res_data_o;
        chk("w8_mul_id_err", {b8.res_id_o, b8.res_err_o}, {3'd7, 1'b0});
      end
    end
    chk("w8_mul_latency", first_k, 9);
    chk("w8_mul_data", data8, 91);
    step();

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
